// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder built around one full-adder slice.
// Operands are shifted LSB-first through the slice, one bit per clock, and the
// result is assembled in a shift register. The result is published on Sum and
// CarryOut in a single DONE cycle.
// Optional feature: define SERIAL_ADDER_SUB_EN to add a Sub input that turns
// the operation into A-B (two's complement, CarryOut = no borrow).
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             Sub,
`endif
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CarryIn,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             CarryOut
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  // Operand B and the initial carry as they enter the working registers.
  logic [WIDTH-1:0] load_b;
  logic             load_carry;

`ifdef SERIAL_ADDER_SUB_EN
  // Subtraction is A + ~B + 1; CarryIn plays no part in that case.
  assign load_b     = Sub ? ~B : B;
  assign load_carry = Sub ? 1'b1 : CarryIn;
`else
  assign load_b     = B;
  assign load_carry = CarryIn;
`endif

  // The single full-adder slice working on the current LSBs.
  logic slice_sum;
  logic slice_carry;
  assign slice_sum   = opa_q[0] ^ opb_q[0] ^ carry_q;
  assign slice_carry = (opa_q[0] & opb_q[0]) | (opa_q[0] & carry_q) | (opb_q[0] & carry_q);

  // Next-state and datapath update for the IDLE -> SHIFT -> DONE sequence.
  always_comb begin
    // NOTE: every _d gets its hold value first so no path leaves one unassigned,
    // which would otherwise infer a latch.
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    res_d   = res_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          opa_d   = A;
          opb_d   = load_b;
          carry_d = load_carry;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        opa_d   = opa_q >> 1;
        opb_d   = opb_q >> 1;
        carry_d = slice_carry;
        res_d   = {slice_sum, res_q[WIDTH-1:1]};
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          // Publish the complete result so it is visible during DONE.
          sum_d   = {slice_sum, res_q[WIDTH-1:1]};
          cout_d  = slice_carry;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous, active-high reset.
  always_ff @(posedge clk) begin
    // NOTE: registers are written with <= so every flop samples the values from
    // before this edge, independent of statement order.
    if (rst) begin
      state_q <= IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign Sum      = sum_q;
  assign CarryOut = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed cases with literal expectations, then random
// traffic (including start spam and resets) checked every cycle against a
// timestamp-based arithmetic model.
module tb_serial_adder;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             CarryIn;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Sum;
  logic             CarryOut;
`ifdef SERIAL_ADDER_SUB_EN
  logic             sub;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
`ifdef SERIAL_ADDER_SUB_EN
    .Sub      (sub),
`endif
    .A        (A),
    .B        (B),
    .CarryIn  (CarryIn),
    .busy     (busy),
    .done     (done),
    .Sum      (Sum),
    .CarryOut (CarryOut)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: an accepted start at edge e makes the DUT busy for cycles
  // e..e+WIDTH, with done in cycle e+WIDTH, where cycle c is the interval after
  // edge c. The result is plain A+B+CarryIn (or A-B).
  // ---------------------------------------------------------------------------
  int             cyc     = 0;
  int             done_at = -1;
  logic [WIDTH:0] pend    = '0;
  logic [WIDTH:0] m_res   = '0;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      done_at = -1;
      m_res   = '0;
    end else begin
      if (cyc == done_at) m_res = pend;
      if (!(done_at >= 0 && cyc - 1 <= done_at) && start) begin
        done_at = cyc + WIDTH;
        pend = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, CarryIn};
`ifdef SERIAL_ADDER_SUB_EN
        if (sub) pend = {1'b0, A} + {1'b0, ~B} + (WIDTH+1)'(1);
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (cyc > 0) begin
      check("busy",     64'(busy),     64'(done_at >= 0 && cyc <= done_at));
      check("done",     64'(done),     64'(cyc == done_at));
      check("Sum",      64'(Sum),      64'(m_res[WIDTH-1:0]));
      check("CarryOut", 64'(CarryOut), 64'(m_res[WIDTH]));
    end
  end

  // ---------------------------------------------------------------------------
  // Directed helpers (called at a negedge with the DUT idle).
  // ---------------------------------------------------------------------------
  task automatic launch(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic cin);
    A       = a;
    B       = b;
    CarryIn = cin;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Returns the number of cycles after the first SHIFT cycle until done is seen.
  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < WIDTH + 4) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic cin, input logic [WIDTH-1:0] exp_sum, input logic exp_cout);
    int lat;
    launch(a, b, cin);
    wait_done(lat);
    check({tag, " latency"}, 64'(lat), 64'(WIDTH));
    check({tag, " Sum"}, 64'(Sum), 64'(exp_sum));
    check({tag, " CarryOut"}, 64'(CarryOut), 64'(exp_cout));
    @(negedge clk);
    check({tag, " idle after done"}, 64'(busy), 64'(0));
  endtask

  initial begin
    int lat;
    int extra_done;
    // Watchdog: the run is a few thousand cycles; anything far beyond is a hang.
    fork
      begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
      end
    join_none

    rst     = 1'b1;
    start   = 1'b1;
    A       = 8'hAA;
    B       = 8'h55;
    CarryIn = 1'b1;
`ifdef SERIAL_ADDER_SUB_EN
    sub     = 1'b0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset busy",     64'(busy),     64'(0));
    check("reset done",     64'(done),     64'(0));
    check("reset Sum",      64'(Sum),      64'(0));
    check("reset CarryOut", 64'(CarryOut), 64'(0));
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("no start out of reset", 64'(busy), 64'(0));

    run_op("add 35+4A",    8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0);
    run_op("ripple FF+00+1", 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1);
    run_op("ripple FF+FF+1", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);

    // Start while busy: the second request must vanish.
    A = 8'h80; B = 8'h80; CarryIn = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    A = 8'h01; B = 8'h01; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat);
    check("busy-start first done", 64'(done), 64'(1));
    check("busy-start Sum", 64'(Sum), 64'(8'h00));
    check("busy-start CarryOut", 64'(CarryOut), 64'(1));
    extra_done = 0;
    repeat (WIDTH + 4) begin
      @(negedge clk);
      if (done) extra_done++;
    end
    check("busy-start second done", 64'(extra_done), 64'(0));
    check("busy-start idle", 64'(busy), 64'(0));

    // Reset during the 4th SHIFT cycle.
    run_op("pre-abort 55+11", 8'h55, 8'h11, 1'b0, 8'h66, 1'b0);
    launch(8'h55, 8'h11, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort busy", 64'(busy), 64'(0));
    check("abort Sum", 64'(Sum), 64'(0));
    check("abort CarryOut", 64'(CarryOut), 64'(0));
    extra_done = 0;
    repeat (WIDTH + 4) begin
      @(negedge clk);
      if (done) extra_done++;
    end
    check("abort no done", 64'(extra_done), 64'(0));
    run_op("after abort 10+20", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0);

`ifdef SERIAL_ADDER_SUB_EN
    sub = 1'b1;
    run_op("sub 10-01", 8'h10, 8'h01, 1'b1, 8'h0F, 1'b1);
    run_op("sub 01-02", 8'h01, 8'h02, 1'b0, 8'hFF, 1'b0);
    sub = 1'b0;
`endif

    // Random traffic: start spam, held start, occasional reset.
    for (int i = 0; i < 3000; i++) begin
      A       = WIDTH'($urandom);
      B       = WIDTH'($urandom);
      CarryIn = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
      sub     = 1'($urandom);
`endif
      start   = ($urandom_range(0, 2) != 0);
      rst     = ($urandom_range(0, 199) == 0);
      @(negedge clk);
    end
    rst   = 1'b0;
    start = 1'b0;
    repeat (WIDTH + 4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial N-bit adder: one full-adder bit-slice per clock plus a registered carry.
- Sits upstream of the combinational full-adder datapath as its area-optimised sequential front end. Loads two operands, shifts them LSB-first through a single full-adder slice and assembles the result.
- start/busy/done handshake to the controlling logic.

Parameters:
- WIDTH, 8, operand and result width in bits (>= 2)

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  one-cycle request; sampled only in IDLE
- A  input  WIDTH  operand A, captured on accepted start
- B  input  WIDTH  operand B, captured on accepted start
- CarryIn  input  1  initial carry, captured on accepted start
- busy  output  1  high while in SHIFT or DONE
- done  output  1  one-cycle pulse when Sum/CarryOut are updated
- Sum  output  WIDTH  registered result of A+B+CarryIn
- CarryOut  output  1  registered carry out of bit WIDTH-1

Behaviour:
- Interface: single clock clk; reset rst is synchronous and active-high.
- Reset, synchronous on rst=1 at a rising edge:
  - state=IDLE; busy=0, done=0, Sum=0, CarryOut=0
  - internal shift registers, carry FF and bit counter cleared
  - rst has priority over every other input.
- States:
  - IDLE: busy=0. start=1 -> capture A, B and CarryIn into working registers (opA, opB, carry); bit counter=0; go to SHIFT.
  - SHIFT: busy=1. Each cycle:
    - s = opA[0]^opB[0]^carry
    - carry <= majority(opA[0], opB[0], carry)
    - opA and opB shift right by 1
    - s shifts into the MSB of the working result register (right shift)
    - counter increments.
    - After the WIDTH-th shift cycle (counter==WIDTH-1 at the edge), go to DONE.
  - DONE: busy=1, done=1 for exactly this cycle.
    - Sum <= working result; CarryOut <= final carry (both loaded on entry to DONE and visible in the DONE cycle).
    - Next cycle go to IDLE unconditionally.
- Latency:
  - start accepted at edge k -> SHIFT cycles k+1..k+WIDTH -> done high in cycle k+WIDTH+1.
  - Throughput: one addition per WIDTH+2 cycles.
- Sum/CarryOut hold their last value until the next DONE; they never show partial results.
- start while busy=1 (SHIFT or DONE) is ignored, with no queueing. A and B may change freely after acceptance.
- start held high continuously: re-accepted in the first IDLE cycle after DONE.
- Arithmetic is modulo 2^WIDTH in Sum, with the overflow bit in CarryOut. {CarryOut,Sum} = A+B+CarryIn exactly.
- rst asserted mid-SHIFT or in DONE: operation aborted, no done pulse; Sum/CarryOut cleared to 0.
- Counter width: clog2(WIDTH)+1 bits; no wrap before the terminal compare.

Optional Feature:
- Macro SERIAL_ADDER_SUB_EN.
- Defined:
  - Adds port Sub (input, 1), captured with the operands on accepted start.
  - Sub=1 -> opB loaded as ~B and initial carry forced to 1, so Sum = A-B mod 2^WIDTH. CarryIn is ignored; CarryOut=1 means no borrow (A>=B unsigned).
  - Sub=0 -> identical to the base behaviour.
- Not defined: no Sub port; addition only.

Test Plan:
- Reset: rst=1 for 2 cycles with start=1 -> busy=0, done=0, Sum=0, CarryOut=0; no operation starts.
- Basic add, WIDTH=8: A=8'h35, B=8'h4A, CarryIn=0, start pulse -> done exactly 9 cycles after the accept edge; Sum=8'h7F, CarryOut=0.
- Full carry ripple: A=8'hFF, B=8'h00, CarryIn=1 -> Sum=8'h00, CarryOut=1. Also A=8'hFF, B=8'hFF, CarryIn=1 -> Sum=8'hFF, CarryOut=1.
- Start while busy: second start with A=8'h01, B=8'h01 mid-SHIFT -> ignored; the first result is delivered and busy returns to 0 with no second done.
- Reset mid-operation: rst in the 4th SHIFT cycle -> no done pulse, Sum=0, CarryOut=0. A new start (A=8'h10, B=8'h20) afterwards gives Sum=8'h30, CarryOut=0.
- Sub mode (SERIAL_ADDER_SUB_EN): A=8'h10, B=8'h01, Sub=1 -> Sum=8'h0F, CarryOut=1. A=8'h01, B=8'h02, Sub=1 -> Sum=8'hFF, CarryOut=0.
